// File: rtl/io_bus_pkg.sv
// Shared types and constants for the I/O bus bridge.
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [15:0] IO_BASE_HI_DEF = 16'hFFFF;
  localparam logic [31:0] ERR_RDATA      = 32'h0;

endpackage

// File: rtl/io_lane_align.sv
// Byte-lane steering for stores, load extraction/extension, alignment checks.
module io_lane_align
  import io_bus_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection, extension and legality of the size/offset combination.
  always_comb begin
    strb       = '0;
    wdata_lane = wdata;
    rdata_ext  = ERR_RDATA;
    err        = 1'b0;
    byte_sel   = 8'(rdata >> {addr_lo, 3'b000});
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          strb       = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        F3_SH: begin
          strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lane = {2{wdata[15:0]}};
          err        = addr_lo[0];
        end
        F3_SW: begin
          strb = 4'b1111;
          err  = |addr_lo;
        end
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
        F3_LBU: rdata_ext = {24'h0, byte_sel};
        F3_LH: begin
          rdata_ext = {{16{half_sel[15]}}, half_sel};
          err       = addr_lo[0];
        end
        F3_LHU: begin
          rdata_ext = {16'h0, half_sel};
          err       = addr_lo[0];
        end
        F3_LW: begin
          rdata_ext = rdata;
          err       = |addr_lo;
        end
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/io_bus_bridge.sv
// Memory-stage bridge from I/O-region loads/stores to a valid/ready bus.
module io_bus_bridge
  import io_bus_pkg::*;
#(
  parameter logic [15:0] IO_BASE_HI     = IO_BASE_HI_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        IOSelM,
  output logic        StallM,
  output logic [31:0] ReadDataIO,
  output logic        ErrM,
  output logic        err_sticky,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  state_t          state, state_next;
  logic [CNT_W-1:0] cnt;
  logic            err_q;
  logic [2:0]      f3_q;
  logic [1:0]      alo_q;
  logic            timeout_hit;

  logic            ln_store;
  logic [2:0]      ln_f3;
  logic [1:0]      ln_alo;
  logic [3:0]      ln_strb;
  logic [31:0]     ln_wdata;
  logic [31:0]     ln_rdata;
  logic            ln_err;

  assign IOSelM      = (ALUResultM[31:16] == IO_BASE_HI) & (MemWriteM | MemReadM);
  assign StallM      = rst & IOSelM & (state != ST_DONE);
  assign bus_valid   = (state == ST_REQ);
  assign ErrM        = (state == ST_DONE) & err_q;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // One aligner serves both directions: live inputs in IDLE for the request
  // and error check, registered size/offset afterwards for load extraction.
  assign ln_store = (state == ST_IDLE) ? MemWriteM        : bus_we;
  assign ln_f3    = (state == ST_IDLE) ? funct3M          : f3_q;
  assign ln_alo   = (state == ST_IDLE) ? ALUResultM[1:0]  : alo_q;

  io_lane_align u_align (
    .is_store   (ln_store),
    .funct3     (ln_f3),
    .addr_lo    (ln_alo),
    .wdata      (WriteDataM),
    .rdata      (bus_rdata),
    .strb       (ln_strb),
    .wdata_lane (ln_wdata),
    .rdata_ext  (ln_rdata),
    .err        (ln_err)
  );

  // Next-state: accept, response wait, timeout abort, one-cycle completion.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (IOSelM) state_next = ln_err ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (bus_ready)        state_next = bus_we ? ST_DONE : ST_WAIT;
        else if (timeout_hit) state_next = ST_DONE;
      end
      ST_WAIT: if (bus_rvalid || timeout_hit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, request registers, timeout counter, load result and error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      err_q      <= 1'b0;
      err_sticky <= 1'b0;
      f3_q       <= '0;
      alo_q      <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_strb   <= '0;
      ReadDataIO <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (IOSelM) begin
            cnt        <= '0;
            err_q      <= ln_err;
            ReadDataIO <= ERR_RDATA;
            if (!ln_err) begin
              bus_we    <= MemWriteM;
              bus_addr  <= {ALUResultM[31:2], 2'b00};
              bus_wdata <= ln_wdata;
              bus_strb  <= ln_strb;
              f3_q      <= funct3M;
              alo_q     <= ALUResultM[1:0];
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt + 1'b1;
          if (!bus_ready && timeout_hit) err_q <= 1'b1;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid)       ReadDataIO <= ln_rdata;
          else if (timeout_hit) err_q      <= 1'b1;
        end
        ST_DONE: err_sticky <= err_sticky | err_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_bridge.sv
module tb_io_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWriteM = 1'b0;
  logic        MemReadM = 1'b0;
  logic [2:0]  funct3M = 3'b0;
  logic [31:0] ALUResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic        IOSelM;
  logic        StallM;
  logic [31:0] ReadDataIO;
  logic        ErrM;
  logic        err_sticky;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  io_bus_bridge #(
    .IO_BASE_HI     (16'hFFFF),
    .TIMEOUT_CYCLES (255),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .IOSelM     (IOSelM),
    .StallM     (StallM),
    .ReadDataIO (ReadDataIO),
    .ErrM       (ErrM),
    .err_sticky (err_sticky),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_strb   (bus_strb),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          chk_data;
  } bus_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    bit          chk_rd;
    int          stalls;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  bus_exp_t  mb;
  done_exp_t md;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt = 0;

  int          cfg_ready_lat = 0;
  int          cfg_rvalid_lat = 0;
  logic [31:0] cfg_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input bit cd);
    bus_exp_t e;
    e.we = we; e.addr = a; e.wdata = wd; e.strb = st; e.chk_data = cd;
    bus_q.push_back(e);
  endtask

  task automatic exp_done(input logic er, input logic [31:0] rd, input bit cr, input int st);
    done_exp_t e;
    e.err = er; e.rd = rd; e.chk_rd = cr; e.stalls = st;
    done_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    MemWriteM = we; MemReadM = re; funct3M = f3; ALUResultM = a; WriteDataM = wd;
  endtask

  task automatic idle_inputs();
    MemWriteM = 1'b0; MemReadM = 1'b0; funct3M = 3'b0; ALUResultM = 32'h0; WriteDataM = 32'h0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (IOSelM && !StallM) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no completion within 400 cycles", name);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Peripheral model: ready after cfg_ready_lat REQ cycles (never if negative),
  // read data cfg_rvalid_lat cycles after the first WAIT cycle.
  bit   rd_pending = 1'b0;
  bit   last_valid = 1'b0;
  bit   last_we = 1'b0;
  int   rcnt = 0;
  int   wcnt = 0;
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      rd_pending = 1'b0; rcnt = 0; last_valid = 1'b0;
    end else begin
      if (bus_ready && last_valid && !last_we) begin
        rd_pending = 1'b1;
        wcnt = 0;
      end
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
      if (rd_pending) begin
        if (wcnt == cfg_rvalid_lat) begin
          bus_rvalid = 1'b1;
          bus_rdata  = cfg_rdata;
          rd_pending = 1'b0;
        end
        wcnt++;
      end
      if (bus_valid) begin
        bus_ready = (cfg_ready_lat >= 0) && (rcnt >= cfg_ready_lat);
        rcnt++;
      end else begin
        bus_ready = 1'b0;
        rcnt = 0;
      end
      last_valid = bus_valid;
      last_we    = bus_we;
    end
  end

  // Monitor: checks each bus handshake and each completion against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      stall_cnt = 0;
    end else begin
      if (StallM) stall_cnt++;
      if (bus_valid && bus_ready) begin
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bus_unexpected: got request addr %h expected none", bus_addr);
        end else begin
          mb = bus_q.pop_front();
          chk("bus_we", 32'(bus_we), 32'(mb.we));
          chk("bus_addr", bus_addr, mb.addr);
          if (mb.chk_data) begin
            chk("bus_wdata", bus_wdata, mb.wdata);
            chk("bus_strb", 32'(bus_strb), 32'(mb.strb));
          end
        end
      end
      if (IOSelM && !StallM) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got completion expected none");
        end else begin
          md = done_q.pop_front();
          chk("ErrM", 32'(ErrM), 32'(md.err));
          if (md.chk_rd) chk("ReadDataIO", ReadDataIO, md.rd);
          chk("stall_cycles", 32'(stall_cnt), 32'(md.stalls));
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bus_valid", 32'(bus_valid), 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_strb", 32'(bus_strb), 32'h0);
    chk("rst_ErrM", 32'(ErrM), 32'h0);
    chk("rst_err_sticky", 32'(err_sticky), 32'h0);
    chk("rst_ReadDataIO", ReadDataIO, 32'h0);
    chk("rst_StallM", 32'(StallM), 32'h0);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // SW, ready in first REQ cycle
    cfg_ready_lat = 0;
    exp_bus(1'b1, 32'hFFFF_0008, 32'h1234_5678, 4'b1111, 1'b1);
    exp_done(1'b0, 32'h0, 1'b0, 2);
    issue(1'b1, 1'b0, 3'b010, 32'hFFFF_0008, 32'h1234_5678);
    wait_done("sw_basic");
    chk("sticky_after_sw", 32'(err_sticky), 32'h0);

    // LB / LBU, byte 3, rvalid in second WAIT cycle
    cfg_rvalid_lat = 1; cfg_rdata = 32'h8000_0000;
    exp_bus(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, 1'b0);
    exp_done(1'b0, 32'hFFFF_FF80, 1'b1, 4);
    issue(1'b0, 1'b1, 3'b000, 32'hFFFF_0003, 32'h0);
    wait_done("lb");
    exp_bus(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, 1'b0);
    exp_done(1'b0, 32'h0000_0080, 1'b1, 4);
    issue(1'b0, 1'b1, 3'b100, 32'hFFFF_0003, 32'h0);
    wait_done("lbu");

    // SH upper half, then misaligned SH
    exp_bus(1'b1, 32'hFFFF_0000, 32'hABCD_ABCD, 4'b1100, 1'b1);
    exp_done(1'b0, 32'h0, 1'b0, 2);
    issue(1'b1, 1'b0, 3'b001, 32'hFFFF_0002, 32'h0000_ABCD);
    wait_done("sh_hi");
    exp_done(1'b1, 32'h0, 1'b0, 1);
    issue(1'b1, 1'b0, 3'b001, 32'hFFFF_0001, 32'h0000_ABCD);
    wait_done("sh_misaligned");
    chk("sticky_after_err", 32'(err_sticky), 32'h1);

    // SB lane 1
    exp_bus(1'b1, 32'hFFFF_0004, 32'hA5A5_A5A5, 4'b0010, 1'b1);
    exp_done(1'b0, 32'h0, 1'b0, 2);
    issue(1'b1, 1'b0, 3'b000, 32'hFFFF_0005, 32'h0000_00A5);
    wait_done("sb_lane1");

    // LH upper (sign), LHU upper (zero), LW; minimum read latency
    cfg_rvalid_lat = 0; cfg_rdata = 32'h8765_4321;
    exp_bus(1'b0, 32'hFFFF_0004, 32'h0, 4'h0, 1'b0);
    exp_done(1'b0, 32'hFFFF_8765, 1'b1, 3);
    issue(1'b0, 1'b1, 3'b001, 32'hFFFF_0006, 32'h0);
    wait_done("lh");
    cfg_rdata = 32'hF00D_0000;
    exp_bus(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, 1'b0);
    exp_done(1'b0, 32'h0000_F00D, 1'b1, 3);
    issue(1'b0, 1'b1, 3'b101, 32'hFFFF_0002, 32'h0);
    wait_done("lhu");
    cfg_rdata = 32'hDEAD_BEEF;
    exp_bus(1'b0, 32'hFFFF_000C, 32'h0, 4'h0, 1'b0);
    exp_done(1'b0, 32'hDEAD_BEEF, 1'b1, 3);
    issue(1'b0, 1'b1, 3'b010, 32'hFFFF_000C, 32'h0);
    wait_done("lw");

    // LW with ready stuck low: timeout abort after 255 counted cycles
    cfg_ready_lat = -1;
    exp_done(1'b1, 32'h0, 1'b1, 256);
    issue(1'b0, 1'b1, 3'b010, 32'hFFFF_0020, 32'h0);
    repeat (100) @(negedge clk);
    chk("hang_bus_valid", 32'(bus_valid), 32'h1);
    chk("hang_bus_addr", bus_addr, 32'hFFFF_0020);
    wait_done("lw_timeout");
    cfg_ready_lat = 0;

    // Illegal accesses: misaligned LW, funct3 011 load, funct3 100 store
    exp_done(1'b1, 32'h0, 1'b1, 1);
    issue(1'b0, 1'b1, 3'b010, 32'hFFFF_0002, 32'h0);
    wait_done("lw_misaligned");
    exp_done(1'b1, 32'h0, 1'b1, 1);
    issue(1'b0, 1'b1, 3'b011, 32'hFFFF_0000, 32'h0);
    wait_done("ld_f3_011");
    exp_done(1'b1, 32'h0, 1'b0, 1);
    issue(1'b1, 1'b0, 3'b100, 32'hFFFF_0000, 32'h0);
    wait_done("st_f3_100");

    // MemWrite and MemRead together behave as a store
    exp_bus(1'b1, 32'hFFFF_0010, 32'h0F0F_0F0F, 4'b1111, 1'b1);
    exp_done(1'b0, 32'h0, 1'b0, 2);
    issue(1'b1, 1'b1, 3'b010, 32'hFFFF_0010, 32'h0F0F_0F0F);
    wait_done("we_and_re");

    // SW with ready after 3 waiting REQ cycles
    cfg_ready_lat = 3;
    exp_bus(1'b1, 32'hFFFF_001C, 32'h1122_3344, 4'b1111, 1'b1);
    exp_done(1'b0, 32'h0, 1'b0, 5);
    issue(1'b1, 1'b0, 3'b010, 32'hFFFF_001C, 32'h1122_3344);
    wait_done("sw_slow_ready");
    cfg_ready_lat = 0;

    // Store outside I/O region
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'hCAFE_0000);
    @(negedge clk);
    chk("nonio_IOSelM", 32'(IOSelM), 32'h0);
    chk("nonio_StallM", 32'(StallM), 32'h0);
    chk("nonio_bus_valid", 32'(bus_valid), 32'h0);
    @(posedge clk); #1;
    idle_inputs();

    // Reset asserted while waiting for read data
    cfg_rvalid_lat = 1000;
    exp_bus(1'b0, 32'hFFFF_0010, 32'h0, 4'h0, 1'b0);
    issue(1'b0, 1'b1, 3'b010, 32'hFFFF_0010, 32'h0);
    repeat (3) @(negedge clk);
    chk("wait_StallM", 32'(StallM), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_bus_valid", 32'(bus_valid), 32'h0);
    chk("midrst_StallM", 32'(StallM), 32'h0);
    idle_inputs();
    @(negedge clk);
    #1 rst = 1'b1;
    cfg_rvalid_lat = 0;
    @(posedge clk); #1;
    chk("sticky_cleared", 32'(err_sticky), 32'h0);
    exp_bus(1'b1, 32'hFFFF_0004, 32'h55AA_55AA, 4'b1111, 1'b1);
    exp_done(1'b0, 32'h0, 1'b0, 2);
    issue(1'b1, 1'b0, 3'b010, 32'hFFFF_0004, 32'h55AA_55AA);
    wait_done("sw_post_reset");

    // Back-to-back SW then LW
    cfg_rdata = 32'h0BAD_F00D;
    exp_bus(1'b1, 32'hFFFF_0014, 32'h0000_0001, 4'b1111, 1'b1);
    exp_done(1'b0, 32'h0, 1'b0, 2);
    exp_bus(1'b0, 32'hFFFF_0018, 32'h0, 4'h0, 1'b0);
    exp_done(1'b0, 32'h0BAD_F00D, 1'b1, 3);
    issue(1'b1, 1'b0, 3'b010, 32'hFFFF_0014, 32'h0000_0001);
    wait_done("b2b_sw");
    issue(1'b0, 1'b1, 3'b010, 32'hFFFF_0018, 32'h0);
    wait_done("b2b_lw");

    repeat (3) @(negedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
    chk("done_q_drained", 32'(done_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_bus_bridge.md
Name: io_bus_bridge

Overview:
- Memory-stage companion to the 5-stage RV32I core's data memory.
- Claims loads/stores whose address lies in the I/O region and performs them on an external valid/ready peripheral bus.
- Stalls the pipeline until each access completes.
- Supplies load data (lane-aligned, sign/zero-extended) to the writeback mux alongside Data_Memory's ReadData.

Parameters:
- IO_BASE_HI, 16'hFFFF: address[31:16] value that selects the I/O region.
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before abort.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- MemWriteM  in  1  store in M stage
- MemReadM  in  1  load in M stage
- funct3M  in  3  RV32I load/store size/sign code
- ALUResultM  in  32  effective address
- WriteDataM  in  32  store data (unaligned, low bits significant)
- IOSelM  out  1  address in I/O region and MemWriteM|MemReadM; combinational
- StallM  out  1  freeze F/D/E/M registers this cycle
- ReadDataIO  out  32  extended load result, valid in DONE
- ErrM  out  1  access error, pulse in DONE
- err_sticky  out  1  set on any error, cleared only by reset
- bus_valid  out  1  request valid
- bus_ready  in  1  request accepted
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_strb  out  4  byte enables
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data

Behaviour:
- Reset (async, rst=0): state IDLE; bus_valid, bus_we, ErrM, err_sticky, counter = 0; bus_addr/wdata/strb = 0; ReadDataIO = 0. Reset mid-transaction drops bus_valid immediately; the access is abandoned.
- IOSelM = (ALUResultM[31:16]==IO_BASE_HI) & (MemWriteM|MemReadM). When IOSelM=0 the block is inert, StallM=0.
- StallM = IOSelM & (state != DONE); combinational.
- MemWriteM and MemReadM both high: treated as a store.
- Alignment rules: LW/SW need addr[1:0]==0. LH/LHU/SH need addr[0]==0. funct3 011/110/111 (and 100/101 on stores) are illegal. Any violation is an error.
- FSM:
  - IDLE: IOSelM & error -> DONE with err flag, no bus activity (1 stall cycle). IOSelM & legal -> REQ; register addr/wdata/strb/we/size; counter=0.
  - REQ: bus_valid=1; request held stable until bus_ready. On accept: write -> DONE, read -> WAIT.
  - WAIT: bus_valid=0; on bus_rvalid capture bus_rdata, then DONE.
  - REQ and WAIT: counter increments each cycle. Reaching TIMEOUT_CYCLES without completion -> DONE with err; bus_valid drops; read data forced 0.
  - DONE: StallM=0; ErrM = err flag; ReadDataIO valid; err_sticky |= err. Unconditionally -> IDLE (the pipeline advances this cycle).
- Back-to-back I/O accesses: the next access is seen in IDLE the following cycle. No bubble is needed beyond the IDLE cycle.
- Minimum stall: write 2 cycles (IDLE, REQ with ready=1); read 3 cycles (IDLE, REQ, WAIT with rvalid=1).
- Store lanes:
  - SB: strb = 4'b0001<<addr[1:0]; wdata = byte replicated x4.
  - SH: strb = addr[1] ? 1100 : 0011; wdata = halfword replicated x2.
  - SW: strb = 1111; wdata passes through.
- Load extraction: byte/half selected by addr[1:0] from the captured rdata. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Error -> ReadDataIO = 0.
- bus_rvalid outside WAIT and bus_ready outside REQ are ignored.

Decomposition:
- Shared package io_bus_pkg:
  - state encoding (IDLE, REQ, WAIT, DONE)
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW
  - IO_BASE_HI default
  - error read value 32'h0
- One combinational sub-module, io_lane_align: strobe/wdata generation, load extraction/extension and alignment-error detection. It is shared by the core's Data_Memory path when sub-word support is added there.

Test Plan:
- SW addr FFFF_0008 data 1234_5678, bus_ready high in first REQ cycle -> bus_strb 1111, bus_addr FFFF_0008, StallM high exactly 2 cycles, ErrM 0.
- LB addr FFFF_0003, rdata 80_00_00_00, rvalid 2 cycles after accept -> ReadDataIO FFFF_FF80, StallM 4 cycles. Same with LBU -> 0000_0080.
- SH addr FFFF_0002 data 0000_ABCD -> strb 1100, wdata ABCD_ABCD. SH addr FFFF_0001 -> no bus_valid, 1 stall cycle, ErrM pulse, err_sticky=1.
- LW with bus_ready stuck 0 -> bus_valid held, addr stable, abort after 255 counted cycles, ReadDataIO 0, ErrM 1, next instruction proceeds.
- rst=0 asserted during WAIT -> bus_valid/StallM 0 immediately, state IDLE; a post-reset SW completes normally.
- Store to 0000_0040 -> IOSelM 0, StallM 0, no bus activity. Back-to-back SW then LW to I/O -> both complete, no overlap of bus_valid.
